// File: rtl/mem_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_pkg : state, owner and poison encodings for the PSRAM arbiter    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mem_bus_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT0  = 2'd1;
   localparam logic [1:0] ST_GNT1  = 2'd2;
   localparam logic [1:0] ST_FLUSH = 2'd3;

   localparam logic [1:0] OWN_IDLE = 2'b00;
   localparam logic [1:0] OWN_M0   = 2'b01;
   localparam logic [1:0] OWN_M1   = 2'b10;

   localparam logic [31:0] POISON = 32'hDEADBEEF;

   // A zero burst length still moves one word.
   function automatic logic [8:0] burst_words(input logic en, input logic [7:0] len);
      if (!en || len == 8'd0) begin
         return 9'd1;
      end
      return {1'b0, len};
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick2 : two-way round-robin picker, favours the master not in last    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last ? 2'b01 : 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter : round-robin sharing of the PSRAM port with access timeout  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mem_arbiter
   import mem_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        burst_en_0,
   input  logic [7:0]  burst_length_0,
   input  logic [31:0] a_0,
   input  logic [31:0] d_0,
   input  logic        we_0,
   input  logic        rd_0,
   output logic [31:0] spo_0,
   output logic        ready_0,
   input  logic [31:0] a_1,
   input  logic [31:0] d_1,
   input  logic        we_1,
   input  logic        rd_1,
   output logic [31:0] spo_1,
   output logic        ready_1,
   output logic        burst_en_mem,
   output logic [7:0]  burst_length_mem,
   output logic [31:0] a_mem,
   output logic [31:0] d_mem,
   output logic        we_mem,
   output logic        rd_mem,
   input  logic [31:0] spo_mem,
   input  logic        ready_mem,
   output logic        err,
   output logic [1:0]  owner
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic        last_q, last_d;
   logic [8:0]  words_left_q, words_left_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        err_q, err_d;

   logic [1:0]  req;
   logic [1:0]  grant;
   logic        word_done;
   logic        timeout_hit;

   assign req = {rd_1 | we_1, rd_0 | we_0};

   rr_pick2 u_pick (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      words_left_d = words_left_q;
      tmo_cnt_d    = tmo_cnt_q;
      err_d        = err_q;
      word_done    = 1'b0;
      timeout_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = 16'd0;
            if (grant[0]) begin
               state_d      = ST_GNT0;
               last_d       = 1'b0;
               words_left_d = burst_words(burst_en_0, burst_length_0);
            end else if (grant[1]) begin
               state_d      = ST_GNT1;
               last_d       = 1'b1;
               words_left_d = 9'd1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            // A real completion beats a timeout landing on the same cycle.
            if (ready_mem) begin
               word_done    = 1'b1;
               tmo_cnt_d    = 16'd0;
               words_left_d = words_left_q - 9'd1;
               if (words_left_q == 9'd1) begin
                  state_d = ST_FLUSH;
               end
            end else if (tmo_cnt_q == TMO_LAST) begin
               timeout_hit = 1'b1;
               err_d       = 1'b1;
               state_d     = ST_FLUSH;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         default: begin
            tmo_cnt_d = 16'd0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      burst_en_mem     = 1'b0;
      burst_length_mem = 8'd0;
      a_mem            = 32'd0;
      d_mem            = 32'd0;
      we_mem           = 1'b0;
      rd_mem           = 1'b0;
      owner            = OWN_IDLE;
      if (state_q == ST_GNT0) begin
         burst_en_mem     = burst_en_0;
         burst_length_mem = burst_length_0;
         a_mem            = a_0;
         d_mem            = d_0;
         we_mem           = we_0;
         rd_mem           = rd_0 & ~we_0;
         owner            = OWN_M0;
      end else if (state_q == ST_GNT1) begin
         a_mem  = a_1;
         d_mem  = d_1;
         we_mem = we_1;
         rd_mem = rd_1 & ~we_1;
         owner  = OWN_M1;
      end
   end

   assign ready_0 = (state_q == ST_GNT0) & (word_done | timeout_hit);
   assign ready_1 = (state_q == ST_GNT1) & (word_done | timeout_hit);
   assign spo_0   = (state_q == ST_GNT0 && timeout_hit) ? POISON : spo_mem;
   assign spo_1   = (state_q == ST_GNT1 && timeout_hit) ? POISON : spo_mem;
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_q       <= 1'b1;
         words_left_q <= 9'd0;
         tmo_cnt_q    <= 16'd0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         words_left_q <= words_left_d;
         tmo_cnt_q    <= tmo_cnt_d;
         err_q        <= err_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random checks against a transaction model  |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        burst_en_0, we_0, rd_0, we_1, rd_1, ready_mem;
   logic [7:0]  burst_length_0;
   logic [31:0] a_0, d_0, a_1, d_1, spo_mem;
   logic [31:0] spo_0, spo_1, a_mem, d_mem;
   logic        ready_0, ready_1, burst_en_mem, we_mem, rd_mem, err;
   logic [7:0]  burst_length_mem;
   logic [1:0]  owner;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .burst_en_0(burst_en_0), .burst_length_0(burst_length_0), .a_0(a_0), .d_0(d_0),
      .we_0(we_0), .rd_0(rd_0), .spo_0(spo_0), .ready_0(ready_0),
      .a_1(a_1), .d_1(d_1), .we_1(we_1), .rd_1(rd_1), .spo_1(spo_1), .ready_1(ready_1),
      .burst_en_mem(burst_en_mem), .burst_length_mem(burst_length_mem), .a_mem(a_mem),
      .d_mem(d_mem), .we_mem(we_mem), .rd_mem(rd_mem), .spo_mem(spo_mem),
      .ready_mem(ready_mem), .err(err), .owner(owner)
   );

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;
   int n_ready0, n_ready1;

   // Transaction-level model: who holds the port, words still owed,
   // cycles waited on the current word, dead cycles before re-arbitration.
   int m_owner, m_left, m_wait, m_dead, m_last;
   bit m_err, m_done0, m_done1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_left = 0; m_wait = 0; m_dead = 0; m_last = 1; m_err = 0;
   endtask

   task automatic check_cycle();
      logic [31:0] e_a, e_d;
      logic [7:0]  e_bl;
      logic [1:0]  e_own;
      logic        e_ben, e_we, e_rd, e_r0, e_r1;
      bit          tmo;
      @(negedge clk);
      cyc_no++;
      tmo = (m_owner >= 0) && !ready_mem && (m_wait == TMO - 1);
      e_a = 0; e_d = 0; e_bl = 0; e_own = 0; e_ben = 0; e_we = 0; e_rd = 0; e_r0 = 0; e_r1 = 0;
      if (m_owner == 0) begin
         e_own = 2'b01; e_ben = burst_en_0; e_bl = burst_length_0; e_a = a_0; e_d = d_0;
         e_we = we_0; e_rd = rd_0 && !we_0; e_r0 = ready_mem || tmo;
      end else if (m_owner == 1) begin
         e_own = 2'b10; e_a = a_1; e_d = d_1; e_we = we_1; e_rd = rd_1 && !we_1;
         e_r1 = ready_mem || tmo;
      end
      chk("owner", owner, e_own);
      chk("burst_en_mem", burst_en_mem, e_ben);
      chk("burst_length_mem", burst_length_mem, e_bl);
      chk("a_mem", a_mem, e_a);
      chk("d_mem", d_mem, e_d);
      chk("we_mem", we_mem, e_we);
      chk("rd_mem", rd_mem, e_rd);
      chk("ready_0", ready_0, e_r0);
      chk("ready_1", ready_1, e_r1);
      if (e_r0) chk("spo_0", spo_0, tmo ? 32'hDEADBEEF : spo_mem);
      if (e_r1) chk("spo_1", spo_1, tmo ? 32'hDEADBEEF : spo_mem);
      chk("err", err, m_err);
      if (ready_0 === 1'b1) n_ready0++;
      if (ready_1 === 1'b1) n_ready1++;
   endtask

   task automatic step();
      bit fin;
      int pick;
      m_done0 = 0; m_done1 = 0; fin = 0; pick = -1;
      if (rst) begin
         model_reset();
      end else if (m_owner >= 0) begin
         if (ready_mem) begin
            m_left--; m_wait = 0; fin = (m_left == 0);
         end else if (m_wait == TMO - 1) begin
            m_err = 1; fin = 1;
         end else begin
            m_wait++;
         end
         if (fin) begin
            if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
            m_owner = -1; m_dead = 1;
         end
      end else if (m_dead > 0) begin
         m_dead--;
      end else begin
         if ((rd_0 | we_0) && (rd_1 | we_1)) pick = (m_last == 1) ? 0 : 1;
         else if (rd_0 | we_0) pick = 0;
         else if (rd_1 | we_1) pick = 1;
         if (pick >= 0) begin
            m_owner = pick; m_last = pick; m_wait = 0;
            if (pick == 0 && burst_en_0) m_left = (burst_length_0 == 0) ? 1 : int'(burst_length_0);
            else m_left = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      check_cycle();
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         ready_mem = 1'b1;
         cyc();
         if (m_done0) begin rd_0 = 0; we_0 = 0; end
         if (m_done1) begin rd_1 = 0; we_1 = 0; end
      end
      ready_mem = 1'b0;
   endtask

   task automatic run_random(input int n, input int pct);
      for (int i = 0; i < n; i++) begin
         ready_mem = ($urandom_range(0, 99) < pct);
         spo_mem   = $urandom;
         if (!(rd_0 | we_0) && $urandom_range(0, 3) == 0) begin
            we_0 = $urandom_range(0, 1);
            rd_0 = !we_0 || ($urandom_range(0, 7) == 0);
            a_0 = $urandom; d_0 = $urandom;
            burst_en_0 = $urandom_range(0, 1);
            burst_length_0 = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
         end
         if (!(rd_1 | we_1) && $urandom_range(0, 3) == 0) begin
            we_1 = $urandom_range(0, 1);
            rd_1 = !we_1 || ($urandom_range(0, 7) == 0);
            a_1 = $urandom; d_1 = $urandom;
         end
         cyc();
         if (m_done0) begin rd_0 = 0; we_0 = 0; end
         if (m_done1) begin rd_1 = 0; we_1 = 0; end
      end
   endtask

   initial begin
      rst = 1'b1;
      burst_en_0 = 0; burst_length_0 = 0; a_0 = 0; d_0 = 0; we_0 = 0; rd_0 = 0;
      a_1 = 0; d_1 = 0; we_1 = 0; rd_1 = 0; spo_mem = 0; ready_mem = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;

      // Reset state
      check_cycle();
      chk("reset_owner", owner, 2'b00);
      chk("reset_err", err, 0);
      chk("reset_rd_mem", rd_mem, 0);
      chk("reset_a_mem", a_mem, 0);
      step();

      // Single master 0 read, ready_mem three cycles after the command
      a_0 = 32'h100; rd_0 = 1; burst_en_0 = 0;
      cyc();
      check_cycle();
      chk("t1_owner", owner, 2'b01);
      chk("t1_a_mem", a_mem, 32'h100);
      chk("t1_rd_mem", rd_mem, 1);
      step();
      cyc(); cyc();
      ready_mem = 1; spo_mem = 32'h12345678;
      check_cycle();
      chk("t1_ready_0", ready_0, 1);
      chk("t1_spo_0", spo_0, 32'h12345678);
      step();
      ready_mem = 0; rd_0 = 0;
      check_cycle();
      chk("t1_owner_released", owner, 2'b00);
      step();
      cyc();

      // Tie after reset: master 0 first, then alternation
      do_reset();
      rd_0 = 1; a_0 = 32'h200; we_1 = 1; a_1 = 32'h300; d_1 = 32'h55AA;
      cyc();
      check_cycle();
      chk("t2_first_owner", owner, 2'b01);
      step();
      ready_mem = 1;
      check_cycle();
      chk("t2_ready_0", ready_0, 1);
      chk("t2_no_ready_1", ready_1, 0);
      step();
      ready_mem = 0; a_0 = 32'h204;
      check_cycle(); chk("t2_flush_owner", owner, 2'b00); step();
      check_cycle(); chk("t2_idle_owner", owner, 2'b00); step();
      check_cycle();
      chk("t2_second_owner", owner, 2'b10);
      chk("t2_a_mem", a_mem, 32'h300);
      chk("t2_we_mem", we_mem, 1);
      step();
      ready_mem = 1;
      check_cycle(); chk("t2_ready_1", ready_1, 1); step();
      ready_mem = 0;
      cyc(); cyc();
      check_cycle(); chk("t2_third_owner", owner, 2'b01); step();
      drain(12);

      // Master 0 burst of 8 while master 1 waits
      burst_en_0 = 1; burst_length_0 = 8; rd_0 = 1; a_0 = 32'h1000;
      cyc();
      rd_1 = 1; a_1 = 32'h2000;
      n_ready0 = 0; n_ready1 = 0;
      for (int i = 0; i < 10; i++) begin
         ready_mem = (i != 2 && i != 5);
         spo_mem = 32'hA000 + i;
         cyc();
         if (m_done0) rd_0 = 0;
      end
      ready_mem = 0;
      chk("t3_ready0_count", n_ready0, 8);
      chk("t3_ready1_count", n_ready1, 0);
      cyc(); cyc();
      check_cycle(); chk("t3_m1_owner", owner, 2'b10); step();
      drain(8);

      // Burst length 0 moves a single word
      burst_en_0 = 1; burst_length_0 = 0; rd_0 = 1; a_0 = 32'h3000;
      cyc();
      ready_mem = 1; spo_mem = 32'h0BAD0001;
      check_cycle(); chk("t4_ready_0", ready_0, 1); step();
      ready_mem = 0; rd_0 = 0;
      check_cycle(); chk("t4_released", owner, 2'b00); step();

      // Timeout on a hung controller
      rd_1 = 1; a_1 = 32'h40;
      cyc();
      for (int i = 0; i < TMO; i++) begin
         check_cycle();
         if (i == TMO - 1) begin
            chk("t5_ready_1", ready_1, 1);
            chk("t5_poison", spo_1, 32'hDEADBEEF);
         end
         step();
      end
      rd_1 = 0;
      check_cycle();
      chk("t5_err_set", err, 1);
      chk("t5_owner", owner, 2'b00);
      step();
      burst_en_0 = 0; rd_0 = 1; a_0 = 32'h80;
      cyc();
      ready_mem = 1; spo_mem = 32'hCAFEF00D;
      check_cycle();
      chk("t5_m0_ready", ready_0, 1);
      chk("t5_m0_spo", spo_0, 32'hCAFEF00D);
      chk("t5_err_sticky", err, 1);
      step();
      ready_mem = 0; rd_0 = 0;
      cyc();

      // Reset during the third word of an 8-word burst
      burst_en_0 = 1; burst_length_0 = 8; rd_0 = 1; a_0 = 32'h5000;
      cyc();
      ready_mem = 1;
      cyc(); cyc();
      ready_mem = 0; rst = 1;
      cyc();
      rst = 0; rd_0 = 0; burst_en_0 = 0;
      check_cycle();
      chk("t6_owner", owner, 2'b00);
      chk("t6_a_mem", a_mem, 0);
      chk("t6_rd_mem", rd_mem, 0);
      chk("t6_burst_en_mem", burst_en_mem, 0);
      chk("t6_err_cleared", err, 0);
      step();
      rd_1 = 1; a_1 = 32'h77;
      cyc();
      ready_mem = 1;
      check_cycle();
      chk("t6_m1_owner", owner, 2'b10);
      chk("t6_m1_a_mem", a_mem, 32'h77);
      chk("t6_m1_ready", ready_1, 1);
      step();
      ready_mem = 0; rd_1 = 0;
      cyc(); cyc();

      // Random traffic: mostly responsive controller, then a sluggish one
      run_random(4000, 45);
      run_random(1500, 8);
      drain(700);
      do_reset();
      check_cycle();
      chk("final_err_cleared", err, 0);
      chk("final_owner", owner, 2'b00);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
